// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer.
// Holds the FSM encoding, layer-config field offsets and base-address steps.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_ADVANCE,
        ST_FINISH
    } state_t;

    localparam int CFG_FIRST   = 0;
    localparam int CFG_LAST_LO = 1;
    localparam int CFG_CONV    = 2;
    localparam int CFG_LAST_HI = 3;
    localparam int CFG_IDX     = 4;
    localparam int CFG_BIAS    = 8;
    localparam int CFG_ACT     = 13;

    localparam logic [19:0] W_INC_3X3 = 20'd144;
    localparam logic [19:0] W_INC_1X1 = 20'd16;
    localparam logic [11:0] P_INC     = 12'd16;

    function automatic logic [15:0] pack_cfg(
        input logic [8:0] desc,
        input logic [3:0] idx,
        input logic       first,
        input logic       last
    );
        logic [15:0] c;
        c = '0;
        c[CFG_ACT +: 3]  = desc[8:6];
        c[CFG_BIAS +: 5] = desc[5:1];
        c[CFG_IDX +: 4]  = idx;
        c[CFG_LAST_HI]   = last;
        c[CFG_CONV]      = desc[0];
        c[CFG_LAST_LO]   = last;
        c[CFG_FIRST]     = first;
        return c;
    endfunction

endpackage

// File: rtl/cnn_seq_desc_table.sv
// Per-layer descriptor register file: one write port, one combinational read port.
// Writes to indices beyond the table depth are dropped.
module cnn_seq_desc_table #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] widx,
    input  logic [8:0] wdata,
    input  logic [3:0] ridx,
    output logic [8:0] rdata
);

    logic [8:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && (int'(widx) < DEPTH)) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = (int'(ridx) < DEPTH) ? mem[ridx] : '0;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer: walks the descriptor table, pulses layer start, tracks bases.
// Optional WAIT watchdog is enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int N_LAYER_MAX    = 16,
    parameter int Ti             = 16,
    parameter int To             = 16,
    parameter int N              = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        desc_we,
    input  logic [3:0]  desc_idx,
    input  logic [8:0]  desc_wdata,
    input  logic [4:0]  num_layers,
    input  logic [19:0] base_weight_init,
    input  logic [11:0] base_param_init,
    input  logic        seq_start,
    input  logic        seq_abort,
    input  logic        acc_layer_done,
    output logic [19:0] acc_base_weight,
    output logic [11:0] acc_base_param,
    output logic [15:0] acc_layer_config,
    output logic        acc_layer_start,
    output logic        seq_busy,
    output logic        seq_done,
    output logic        seq_err,
    output logic [3:0]  cur_layer
);

    // Step constants in the package assume the default array geometry.
    if (N_LAYER_MAX < 1 || N_LAYER_MAX > 16) begin : g_bad_depth
        $error("N_LAYER_MAX must be 1..16");
    end
    if ((Ti * To * 9) / N != int'(W_INC_3X3) || To != int'(W_INC_1X1)
        || To != int'(P_INC)) begin : g_bad_geom
        $error("array geometry does not match increment constants");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2097151) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must fit the 21-bit watchdog");
    end

    state_t      state, next_state;
    logic [4:0]  num_q;
    logic        done_q;
    logic [8:0]  desc_rd;
    logic        rise;
    logic        is_last;
    logic        timeout;

    cnn_seq_desc_table #(.DEPTH(N_LAYER_MAX)) u_table (
        .clk   (HCLK),
        .rst   (HRESET),
        .we    (desc_we),
        .widx  (desc_idx),
        .wdata (desc_wdata),
        .ridx  (cur_layer),
        .rdata (desc_rd)
    );

    // Edge detection so a done level left over from the last layer is ignored.
    assign rise    = acc_layer_done && !done_q;
    assign is_last = ({1'b0, cur_layer} == (num_q - 5'd1));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (seq_start)
                            next_state = (num_layers == 5'd0) ? ST_FINISH : ST_SETUP;
            ST_SETUP:   next_state = ST_START;
            ST_START:   next_state = ST_WAIT;
            ST_WAIT:    if (rise) next_state = ST_ADVANCE;
                        else if (timeout) next_state = ST_FINISH;
            ST_ADVANCE: next_state = is_last ? ST_FINISH : ST_SETUP;
            ST_FINISH:  next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
        if (seq_abort && state != ST_IDLE) next_state = ST_IDLE;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state            <= ST_IDLE;
            done_q           <= 1'b0;
            num_q            <= '0;
            cur_layer        <= '0;
            acc_base_weight  <= '0;
            acc_base_param   <= '0;
            acc_layer_config <= '0;
        end else begin
            state  <= next_state;
            done_q <= acc_layer_done;
            case (state)
                ST_IDLE: if (seq_start) begin
                    num_q           <= num_layers;
                    cur_layer       <= '0;
                    acc_base_weight <= base_weight_init;
                    acc_base_param  <= base_param_init;
                end
                ST_SETUP: if (!seq_abort) begin
                    acc_layer_config <= pack_cfg(desc_rd, cur_layer,
                                                 cur_layer == 4'd0, is_last);
                end
                ST_ADVANCE: if (!seq_abort) begin
                    acc_base_weight <= acc_base_weight +
                        (acc_layer_config[CFG_CONV] ? W_INC_3X3 : W_INC_1X1);
                    acc_base_param  <= acc_base_param + P_INC;
                    if (!is_last) cur_layer <= cur_layer + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign acc_layer_start = (state == ST_START) && !seq_abort;
    assign seq_done        = (state == ST_FINISH) && !seq_abort;
    assign seq_busy        = (state != ST_IDLE);

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam logic [20:0] TMO_LAST = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] tmo_cnt;

    assign timeout = (state == ST_WAIT) && !rise && (tmo_cnt == TMO_LAST);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tmo_cnt <= '0;
            seq_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + 21'd1 : '0;
            if (state == ST_IDLE && seq_start) seq_err <= 1'b0;
            else if (timeout && !seq_abort) seq_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomized self-checking bench for cnn_layer_sequencer.
// Expected configs/bases come from a per-layer arithmetic model of the descriptor table.
module tb_cnn_layer_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        desc_we = 1'b0;
    logic [3:0]  desc_idx = '0;
    logic [8:0]  desc_wdata = '0;
    logic [4:0]  num_layers = '0;
    logic [19:0] base_weight_init = '0;
    logic [11:0] base_param_init = '0;
    logic        seq_start = 1'b0;
    logic        seq_abort = 1'b0;
    logic        acc_layer_done = 1'b0;
    logic [19:0] acc_base_weight;
    logic [11:0] acc_base_param;
    logic [15:0] acc_layer_config;
    logic        acc_layer_start;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_err;
    logic [3:0]  cur_layer;

    int n_checks = 0;
    int n_fail = 0;
    int starts = 0;
    int dones = 0;
    logic [8:0] desc_m [16];

    cnn_layer_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .HCLK             (HCLK),
        .HRESET           (HRESET),
        .desc_we          (desc_we),
        .desc_idx         (desc_idx),
        .desc_wdata       (desc_wdata),
        .num_layers       (num_layers),
        .base_weight_init (base_weight_init),
        .base_param_init  (base_param_init),
        .seq_start        (seq_start),
        .seq_abort        (seq_abort),
        .acc_layer_done   (acc_layer_done),
        .acc_base_weight  (acc_base_weight),
        .acc_base_param   (acc_base_param),
        .acc_layer_config (acc_layer_config),
        .acc_layer_start  (acc_layer_start),
        .seq_busy         (seq_busy),
        .seq_done         (seq_done),
        .seq_err          (seq_err),
        .cur_layer        (cur_layer)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: advance to the next falling edge and tally the pulses seen there.
    task automatic tick();
        @(negedge HCLK);
        if (acc_layer_start) starts++;
        if (seq_done) dones++;
    endtask

    task automatic wait_start(inout int gap);
        while (!acc_layer_start && gap < 400) begin
            tick();
            gap++;
        end
    endtask

    task automatic wait_done(inout int gap);
        while (!seq_done && gap < 400) begin
            tick();
            gap++;
        end
    endtask

    task automatic write_desc(input int idx, input logic [8:0] v);
        desc_we = 1'b1;
        desc_idx = 4'(idx);
        desc_wdata = v;
        tick();
        desc_we = 1'b0;
        desc_m[idx] = v;
    endtask

    task automatic run_seq(input int n, input logic [19:0] bw,
                           input logic [11:0] bp, input int stale_at,
                           input int abort_at, input bit late_write,
                           input int fixed_lat);
        logic [19:0] w;
        logic [11:0] p;
        logic [8:0]  d;
        logic [15:0] cfg;
        bit          first;
        bit          last;
        int          gap;
        int          s0;
        int          d0;
        int          lat;
        w = bw;
        p = bp;
        s0 = starts;
        d0 = dones;
        num_layers = 5'(n);
        base_weight_init = bw;
        base_param_init = bp;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        check("busy_after_start", seq_busy, 1);
        check("err_cleared", seq_err, 0);
        gap = 1;
        wait_start(gap);
        check("first_start_lat", gap, 2);
        for (int i = 0; i < n; i++) begin
            d = desc_m[i];
            first = (i == 0);
            last = (i == n - 1);
            cfg = {d[8:6], d[5:1], 4'(i), last, d[0], last, first};
            check("layer_config", acc_layer_config, cfg);
            check("base_weight", acc_base_weight, w);
            check("base_param", acc_base_param, p);
            check("cur_layer", cur_layer, i);
            w = w + (d[0] ? 20'd144 : 20'd16);
            p = p + 12'd16;
            if (i == abort_at) begin
                repeat (3) tick();
                seq_abort = 1'b1;
                tick();
                seq_abort = 1'b0;
                check("abort_busy", seq_busy, 0);
                tick();
                check("abort_no_done", dones - d0, 0);
                return;
            end
            if (i == stale_at) begin
                repeat (8) tick();
                check("stale_no_advance", starts - s0, i + 1);
                check("stale_busy", seq_busy, 1);
                acc_layer_done = 1'b0;
                tick();
            end
            lat = (fixed_lat > 0) ? fixed_lat - 1 : $urandom_range(2, 12);
            if (late_write && i == 0 && n > 1) begin
                write_desc(n - 1, 9'($urandom));
                lat--;
            end
            repeat (lat) tick();
            acc_layer_done = 1'b1;
            tick();
            if (i + 1 != stale_at) acc_layer_done = 1'b0;
            gap = 1;
            if (last) begin
                wait_done(gap);
                check("seq_done_lat", gap, 2);
                check("final_weight", acc_base_weight, w);
                check("final_param", acc_base_param, p);
                check("start_count", starts - s0, n);
                tick();
                check("idle_after_done", seq_busy, 0);
                tick();
                check("done_count", dones - d0, 1);
            end else begin
                wait_start(gap);
                check("next_start_lat", gap, 3);
            end
        end
    endtask

    initial begin
        int gap;
        int s0;
        int d0;
        int n;
        for (int i = 0; i < 16; i++) desc_m[i] = '0;

        tick();
        tick();
        check("rst_config", acc_layer_config, 0);
        check("rst_weight", acc_base_weight, 0);
        check("rst_param", acc_base_param, 0);
        check("rst_ctrl", {acc_layer_start, seq_busy, seq_done, seq_err}, 0);
        check("rst_layer", cur_layer, 0);
        HRESET = 1'b0;
        tick();

        // Reference three-layer run with 50-cycle layer latency.
        write_desc(0, {3'd7, 5'd9, 1'b0});
        write_desc(1, {3'd7, 5'd17, 1'b1});
        write_desc(2, {3'd7, 5'd17, 1'b1});
        run_seq(3, 20'd0, 12'd0, -1, -1, 1'b0, 50);

        // Empty layer list finishes without any layer start.
        s0 = starts;
        d0 = dones;
        num_layers = 5'd0;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        gap = 1;
        wait_done(gap);
        check("zero_done_seen", seq_done, 1);
        check("zero_done_lat", gap <= 2, 1);
        tick();
        tick();
        check("zero_no_start", starts - s0, 0);
        check("zero_one_done", dones - d0, 1);
        check("zero_idle", seq_busy, 0);

        // Done left high across a layer boundary.
        for (int i = 0; i < 3; i++) write_desc(i, 9'($urandom));
        run_seq(3, 20'($urandom), 12'($urandom), 2, -1, 1'b0, 0);

        // Abort in layer 1, then restart from the init bases.
        for (int i = 0; i < 3; i++) write_desc(i, 9'($urandom));
        run_seq(3, 20'h12340, 12'h560, -1, 1, 1'b0, 0);
        run_seq(3, 20'h12340, 12'h560, -1, -1, 1'b0, 0);

        // Weight base wraps past 2^20.
        write_desc(0, {3'd1, 5'd2, 1'b1});
        write_desc(1, {3'd0, 5'd0, 1'b0});
        run_seq(2, 20'hFFFF0, 12'hFF0, -1, -1, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) write_desc(i, 9'($urandom));
            n = $urandom_range(1, 6);
            run_seq(n, 20'($urandom), 12'($urandom), -1, -1, 1'b1, 0);
        end

        // Asynchronous reset mid-layer wipes state and the table.
        write_desc(0, 9'h1FF);
        num_layers = 5'd2;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        repeat (4) tick();
        #2 HRESET = 1'b1;
        #1;
        check("midrst_busy", seq_busy, 0);
        check("midrst_config", acc_layer_config, 0);
        check("midrst_weight", acc_base_weight, 0);
        tick();
        HRESET = 1'b0;
        for (int i = 0; i < 16; i++) desc_m[i] = '0;
        tick();
        run_seq(1, 20'h00100, 12'h010, -1, -1, 1'b0, 0);

`ifdef CNN_SEQ_TIMEOUT_EN
        num_layers = 5'd1;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        gap = 1;
        wait_start(gap);
        gap = 0;
        wait_done(gap);
        check("timeout_lat", gap, 101);
        check("timeout_err", seq_err, 1);
        tick();
        tick();
        check("timeout_err_sticky", seq_err, 1);
        run_seq(1, 20'd0, 12'd0, -1, -1, 1'b0, 0);
`else
        check("err_tied_low", seq_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
